// File: rtl/vec_to_angle.sv
// Vectoring-mode CORDIC: signed Q16.16 (x, y) -> integer angle in degrees 0..359.
// One computation in flight; start/done handshake; shift-and-add only.
module vec_to_angle #(
   parameter int ITERS = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic signed [31:0] vec_x,
   input  logic signed [31:0] vec_y,
   output logic               ready,
   output logic               done,
   output logic [8:0]         angle,
   output logic               zero_vec
);

   typedef enum logic [1:0] {IDLE, ITER, NORM} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic signed [34:0] r_x;
   logic signed [34:0] r_y;
   logic signed [31:0] r_z;
   logic [3:0]         r_i;
   logic               r_neg;
   logic               r_zero;
   logic               r_done;
   logic [8:0]         r_angle;
   logic               r_zero_vec;

   logic signed [34:0] w_ext_x;
   logic signed [34:0] w_ext_y;
   logic signed [34:0] w_x_sh;
   logic signed [34:0] w_y_sh;
   logic signed [31:0] w_atan;
   logic               w_d;
   logic signed [31:0] w_t;
   logic signed [31:0] w_a;
   logic [8:0]         w_angle;

   // atan(2^-i) in degrees, Q16.16
   function automatic logic signed [31:0] atan_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    return 32'sd2949120;
         4'd1:    return 32'sd1740967;
         4'd2:    return 32'sd919879;
         4'd3:    return 32'sd466945;
         4'd4:    return 32'sd234379;
         4'd5:    return 32'sd117304;
         4'd6:    return 32'sd58666;
         4'd7:    return 32'sd29335;
         4'd8:    return 32'sd14668;
         4'd9:    return 32'sd7334;
         4'd10:   return 32'sd3667;
         4'd11:   return 32'sd1833;
         4'd12:   return 32'sd917;
         4'd13:   return 32'sd458;
         4'd14:   return 32'sd229;
         default: return 32'sd115;
      endcase
   endfunction

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = ITER;
         ITER:    if (r_i == 4'(ITERS - 1)) w_state_next = NORM;
         NORM:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   assign w_ext_x = {{3{vec_x[31]}}, vec_x};
   assign w_ext_y = {{3{vec_y[31]}}, vec_y};
   assign w_x_sh  = r_x >>> r_i;
   assign w_y_sh  = r_y >>> r_i;
   assign w_atan  = atan_lut(r_i);
   assign w_d     = ~r_y[34];

   // Left half-plane inputs were pre-rotated by 180 degrees at load.
   assign w_t = (r_neg ? 32'sd11796480 : 32'sd0) + r_z;
   assign w_a = (w_t + 32'sd32768) >>> 16;

   always_comb begin
      if (w_a < 0)
         w_angle = 9'(w_a + 32'sd360);
      else if (w_a >= 32'sd360)
         w_angle = 9'(w_a - 32'sd360);
      else
         w_angle = 9'(w_a);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_z        <= '0;
         r_i        <= '0;
         r_neg      <= 1'b0;
         r_zero     <= 1'b0;
         r_done     <= 1'b0;
         r_angle    <= '0;
         r_zero_vec <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_x    <= vec_x[31] ? -w_ext_x : w_ext_x;
                  r_y    <= vec_x[31] ? -w_ext_y : w_ext_y;
                  r_neg  <= vec_x[31];
                  r_zero <= (vec_x == 32'sd0) && (vec_y == 32'sd0);
                  r_z    <= '0;
                  r_i    <= '0;
               end
            end
            ITER: begin
               if (w_d) begin
                  r_x <= r_x + w_y_sh;
                  r_y <= r_y - w_x_sh;
                  r_z <= r_z + w_atan;
               end else begin
                  r_x <= r_x - w_y_sh;
                  r_y <= r_y + w_x_sh;
                  r_z <= r_z - w_atan;
               end
               r_i <= r_i + 4'd1;
            end
            NORM: begin
               r_angle    <= r_zero ? 9'd0 : w_angle;
               r_zero_vec <= r_zero;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ready    = (r_state == IDLE);
   assign done     = r_done;
   assign angle    = r_angle;
   assign zero_vec = r_zero_vec;

endmodule

// File: doc/vec_to_angle.md
# vec_to_angle

Iterative CORDIC (vectoring mode) converting a signed Q16.16 vector (x, y) into the integer angle in degrees, 0..359. It is the inverse of the degree-indexed sine/cosine lookup. The lookup turns a 9-bit angle into Q16.16 components; this block turns components (e.g. a look direction or a player-to-block delta) back into the 9-bit angle format used by the camera/orientation logic. It uses a start/done handshake, has one computation in flight at a time, and uses no multipliers.

## Interface
- ITERS, 16: number of CORDIC micro-rotations (legal range 8..16).
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only while ready=1.
- vec_x  in  32  signed Q16.16 x component. Captured on the accepting edge.
- vec_y  in  32  signed Q16.16 y component. Captured on the accepting edge.
- ready  out  1  high in IDLE. Reset value 1.
- done  out  1  one-cycle pulse when angle/zero_vec are updated. Reset value 0.
- angle  out  9  result in degrees, 0..359, counter-clockwise from +x. Holds until the next done. Reset value 0.
- zero_vec  out  1  result flag: input was (0,0). Holds with angle. Reset value 0.

## Operation
- States: IDLE, ITER, NORM.
  - IDLE: start=1 loads the datapath and moves to ITER.
  - ITER: runs ITERS cycles, then moves to NORM.
  - NORM: lasts 1 cycle, then returns to IDLE.
- Load (pre-rotation):
  - Sign-extend x and y to 35 bits. This covers negation of -2^31 and the CORDIC gain of about 1.647.
  - If vec_x < 0: x = -vec_x, y = -vec_y, base = 180. Otherwise base = 0.
  - Set z = 0 and iteration counter i = 0.
- Each ITER cycle, with d = (y >= 0):
  - If d: x += y>>>i, y -= x>>>i, z += ATAN[i].
  - Otherwise: x -= y>>>i, y += x>>>i, z -= ATAN[i].
  - All updates use the old x and y values. Shifts are arithmetic.
- ATAN[i] = round(atan(2^-i) * 180/pi * 2^16), stored as signed 32-bit constants.
  - First values: 2949120, 1740967, 919879, 466945, 234379, 117304, 58666, 29335.
  - Then: 14668, 7334, 3667, 1833, 917, 458, 229, 115.
- NORM:
  - t = base*2^16 + z, signed 32-bit.
  - a = (t + 32768) >>> 16, i.e. round half up.
  - If a < 0, a += 360. If a >= 360, a -= 360.
  - Register angle = a[8:0] and set done = 1.
- Zero vector: if both inputs are 0 at load, NORM forces angle = 0 and zero_vec = 1. Otherwise zero_vec = 0. Latency is unchanged.
- The magnitude is not output. The gain is irrelevant to the angle.

## Timing
- Let E0 be the edge where start=1 is sampled with ready=1.
  - ready falls after E0.
  - E1..E_ITERS are the iterations.
  - At E_(ITERS+1), angle, zero_vec and done=1 are registered and ready returns to 1.
- Latency from E0 to done visible is ITERS+1 cycles, i.e. 17 at the default.
- done is high for exactly one cycle.
- A start in the same cycle that done is high is accepted, since ready=1. Back-to-back throughput is one result per ITERS+2 cycles.
- start while ready=0 is ignored entirely: no queuing, and vec_x/vec_y are not captured.
- Inputs need to be stable only in the accepting cycle.
- reset_n low at any time:
  - Immediately returns to IDLE.
  - Clears done, angle and zero_vec.
  - Sets ready = 1.
  - Any in-flight result is discarded.
- Accuracy: for exact inputs, the result equals round-to-nearest of the true angle whenever the true angle is at least 0.01 degree from an x.5 boundary.

## Test plan
- Axes: (65536,0) -> 0, (0,65536) -> 90, (-65536,0) -> 180, (0,-65536) -> 270. Each gives done exactly 17 cycles after its accepting edge, with zero_vec = 0.
- Off-axis and wrap:
  - (56755,32768) -> 30.
  - (-32768,-56755) -> 240.
  - (65526,-1143) -> 359, not -1 or 360.
  - (-65526,1143) -> 179.
- Zero and extremes:
  - (0,0) -> angle 0, zero_vec 1.
  - (-2^31, 0) -> 180.
  - (2^31-1, 2^31-1) -> 45, with no overflow.
- Handshake:
  - Assert start continuously with changing vectors. Only the vectors present on accepting edges are used.
  - Results arrive every 18 cycles.
  - start pulses while ready=0 produce no extra done.
- Reset mid-operation:
  - Pull reset_n low at cycle 8 of a computation and release it. Verify: no done, angle = 0, ready = 1 asynchronously.
  - A following (0,65536) request returns 90.
- Random: 10,000 random vectors with |x|,|y| >= 2^10, compared against a floating-point atan2 model. Results must match except within 0.01 degree of a rounding boundary.
